// File: rtl/ramio_arbiter_pkg.sv
// rtl/ramio_arbiter_pkg.sv - shared types and encodings for the ramio client-port arbiter
package ramio_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ACK   = 2'd2
    } state_e;

    localparam logic [2:0] ReadNone  = 3'b000;
    localparam logic [1:0] WriteNone = 2'b00;

    localparam logic [1:0] GrantNone = 2'b00;
    localparam logic [1:0] GrantM0   = 2'b01;
    localparam logic [1:0] GrantM1   = 2'b10;

endpackage

// File: rtl/ramio_arbiter_pick.sv
// rtl/ramio_arbiter_pick.sv - two-way fixed-priority / round-robin request picker
module ramio_arbiter_pick
    import ramio_arbiter_pkg::*;
#(
    parameter int FixedPriority = 0
) (
    input  logic [1:0] req,
    input  logic [1:0] last_grant,
    output logic [1:0] pick
);

    always_comb begin
        pick = GrantNone;
        if (req == 2'b11) begin
            // On a tie, round-robin favours whichever master did not own the port last
            if (FixedPriority != 0 || last_grant == GrantM1) begin
                pick = GrantM0;
            end else begin
                pick = GrantM1;
            end
        end else if (req[0]) begin
            pick = GrantM0;
        end else if (req[1]) begin
            pick = GrantM1;
        end
    end

endmodule

// File: rtl/ramio_arbiter.sv
// rtl/ramio_arbiter.sv - shares one ramio client port between fetch (m0) and load/store (m1)
module ramio_arbiter
    import ramio_arbiter_pkg::*;
#(
    parameter int AddressBitWidth = 32,
    parameter int DataBitWidth    = 32,
    parameter int FixedPriority   = 0,
    parameter int TimeoutCycles   = 4096
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       m0_enable,
    input  logic [2:0]                 m0_read_type,
    input  logic [1:0]                 m0_write_type,
    input  logic [AddressBitWidth-1:0] m0_address,
    input  logic [DataBitWidth-1:0]    m0_data_in,
    output logic [DataBitWidth-1:0]    m0_data_out,
    output logic                       m0_ack,
    output logic                       m0_error,

    input  logic                       m1_enable,
    input  logic [2:0]                 m1_read_type,
    input  logic [1:0]                 m1_write_type,
    input  logic [AddressBitWidth-1:0] m1_address,
    input  logic [DataBitWidth-1:0]    m1_data_in,
    output logic [DataBitWidth-1:0]    m1_data_out,
    output logic                       m1_ack,
    output logic                       m1_error,

    output logic                       ramio_enable,
    output logic [2:0]                 ramio_read_type,
    output logic [1:0]                 ramio_write_type,
    output logic [AddressBitWidth-1:0] ramio_address,
    output logic [DataBitWidth-1:0]    ramio_data_in,
    input  logic [DataBitWidth-1:0]    ramio_data_out,
    input  logic                       ramio_data_out_ready,
    input  logic                       ramio_busy,

    output logic [1:0]                 grant
);

    localparam bit TimeoutOn = (TimeoutCycles > 0);
    localparam int TimerBits = TimeoutOn ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [TimerBits-1:0] TimeoutLast = TimeoutOn ? TimerBits'(TimeoutCycles - 1) : '0;

    state_e                  state_q, state_d;
    logic [1:0]              grant_q, grant_d;
    logic [1:0]              last_grant_q, last_grant_d;
    logic [TimerBits-1:0]    timer_q, timer_d;
    logic [1:0]              ack_d, error_d;
    logic [DataBitWidth-1:0] m0_data_d, m1_data_d;
    logic [1:0]              pick;
    logic                    done;

    ramio_arbiter_pick #(
        .FixedPriority(FixedPriority)
    ) u_pick (
        .req       ({m1_enable, m0_enable}),
        .last_grant(last_grant_q),
        .pick      (pick)
    );

    // Outside GRANT the port is driven to all-zero so side-effecting addresses never see a stray access
    always_comb begin
        ramio_enable     = 1'b0;
        ramio_read_type  = ReadNone;
        ramio_write_type = WriteNone;
        ramio_address    = '0;
        ramio_data_in    = '0;
        if (state_q == GRANT) begin
            if (grant_q == GrantM1) begin
                ramio_enable     = m1_enable;
                ramio_read_type  = m1_read_type;
                ramio_write_type = m1_write_type;
                ramio_address    = m1_address;
                ramio_data_in    = m1_data_in;
            end else if (grant_q == GrantM0) begin
                ramio_enable     = m0_enable;
                ramio_read_type  = m0_read_type;
                ramio_write_type = m0_write_type;
                ramio_address    = m0_address;
                ramio_data_in    = m0_data_in;
            end
        end
    end

    assign done = !ramio_busy && (ramio_read_type == ReadNone || ramio_data_out_ready);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        ack_d        = 2'b00;
        error_d      = 2'b00;
        m0_data_d    = m0_data_out;
        m1_data_d    = m1_data_out;
        case (state_q)
            IDLE: begin
                if (pick != GrantNone) begin
                    grant_d = pick;
                    timer_d = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (done) begin
                    ack_d   = grant_q;
                    state_d = ACK;
                    if (grant_q[0]) m0_data_d = ramio_data_out;
                    if (grant_q[1]) m1_data_d = ramio_data_out;
                end else if (TimeoutOn && timer_q == TimeoutLast) begin
                    ack_d   = grant_q;
                    error_d = grant_q;
                    state_d = ACK;
                    if (grant_q[0]) m0_data_d = '0;
                    if (grant_q[1]) m1_data_d = '0;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TimerBits'(1);
                end
            end
            ACK: begin
                last_grant_d = grant_q;
                grant_d      = GrantNone;
                state_d      = IDLE;
            end
            default: begin
                grant_d = GrantNone;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= GrantNone;
            last_grant_q <= GrantM1;
            timer_q      <= '0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_error     <= 1'b0;
            m1_error     <= 1'b0;
            m0_data_out  <= '0;
            m1_data_out  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            m0_ack       <= ack_d[0];
            m1_ack       <= ack_d[1];
            m0_error     <= error_d[0];
            m1_error     <= error_d[1];
            m0_data_out  <= m0_data_d;
            m1_data_out  <= m1_data_d;
        end
    end

    assign grant = grant_q;

endmodule
